// File: rtl/data_mem_dp_pkg.sv
// Shared definitions for the dual-port data memory: default geometry and
// the INIT/RUN state encoding used by the init sequencer.
// Optional feature macro used elsewhere: DATA_MEM_DP_BYPASS_EN.
package data_mem_dp_pkg;

    localparam int W_DEF = 8;   // default data word width
    localparam int A_DEF = 8;   // default address width

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/data_mem_init_seq.sv
// Init sequencer for data_mem_dp: after reset it walks a sweep address from
// word 0 to word DEPTH-1 (one word per cycle, write-enable high), then moves
// to RUN and stays there until the next reset. The current state is exposed
// on state_o for observation.
module data_mem_init_seq
    import data_mem_dp_pkg::*;
#(
    parameter int A     = A_DEF,
    parameter int DEPTH = 2**A
) (
    input  logic         Clk,
    input  logic         ResetN,
    output logic [A-1:0] sweep_addr_o,
    output logic         sweep_we_o,
    output logic         done_o,
    output state_e       state_o
);

    localparam logic [A-1:0] LAST_ADDR = A'(DEPTH - 1);

    state_e       state_q, state_d;
    logic [A-1:0] cnt_q, cnt_d;

    // State and sweep counter registers; reset restarts the sweep at word 0.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= INIT;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: advance one word per cycle, leave INIT after the last word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            INIT: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + A'(1);
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
            end
        endcase
    end

    assign sweep_addr_o = cnt_q;
    assign sweep_we_o   = (state_q == INIT);
    assign done_o       = (state_q == RUN);
    assign state_o      = state_q;

endmodule

// File: rtl/data_mem_dp.sv
// Dual-port data memory: port A read/write, port B read-only, both with a
// one-cycle registered read. After reset an init sweep fills every word with
// INIT_VAL before either port accepts requests. Out-of-range accesses are
// dropped (writes) or return zero (reads) and pulse AddrErr.
// Handshake: a port request is accepted on a rising edge when Req=1 and the
// port's Rdy=1; a request seen while Rdy=0 is ignored. Valid is a one-cycle
// pulse in the cycle after an accepted read; DataOut holds until the next
// accepted read on that port.
// Macro DATA_MEM_DP_BYPASS_EN: when defined, a B read that collides with a
// same-cycle A write to the same address returns the new A write data;
// otherwise it returns the word as it was before the write.
module data_mem_dp
    import data_mem_dp_pkg::*;
#(
    parameter int           W        = W_DEF,
    parameter int           A        = A_DEF,
    parameter int           DEPTH    = 2**A,
    parameter logic [W-1:0] INIT_VAL = '0
) (
    input  logic         Clk,
    input  logic         ResetN,
    input  logic         AReq,
    input  logic         AWe,
    input  logic [A-1:0] AAddr,
    input  logic [W-1:0] ADataIn,
    output logic         ARdy,
    output logic [W-1:0] ADataOut,
    output logic         AValid,
    input  logic         BReq,
    input  logic [A-1:0] BAddr,
    output logic         BRdy,
    output logic [W-1:0] BDataOut,
    output logic         BValid,
    output logic         InitDone,
    output logic         AddrErr
);

    localparam int          IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [A:0]  DEPTH_W = (A + 1)'(DEPTH);

    logic [W-1:0] core [DEPTH];

    logic [A-1:0] sweep_addr;
    logic         sweep_we;
    logic         init_done;
    state_e       seq_state;

    logic          a_acc, b_acc, a_oor, b_oor, a_wr_ok;
    logic [IW-1:0] a_idx, b_idx, sweep_idx;

    logic [W-1:0] a_data_q, a_data_d;
    logic [W-1:0] b_data_q, b_data_d;
    logic         a_valid_q, a_valid_d;
    logic         b_valid_q, b_valid_d;
    logic         addr_err_q, addr_err_d;

    data_mem_init_seq #(
        .A     (A),
        .DEPTH (DEPTH)
    ) u_init_seq (
        .Clk          (Clk),
        .ResetN       (ResetN),
        .sweep_addr_o (sweep_addr),
        .sweep_we_o   (sweep_we),
        .done_o       (init_done),
        .state_o      (seq_state)
    );

    assign a_acc     = AReq && init_done;
    assign b_acc     = BReq && init_done;
    assign a_oor     = ({1'b0, AAddr} >= DEPTH_W);
    assign b_oor     = ({1'b0, BAddr} >= DEPTH_W);
    assign a_wr_ok   = a_acc && AWe && !a_oor;
    assign a_idx     = AAddr[IW-1:0];
    assign b_idx     = BAddr[IW-1:0];
    assign sweep_idx = sweep_addr[IW-1:0];

    // Storage array: sweep writes during INIT, port A writes during RUN.
    // Deliberately not reset; only the sweep initialises it.
    always_ff @(posedge Clk) begin
        if (sweep_we) begin
            core[sweep_idx] <= INIT_VAL;
        end else if (a_wr_ok) begin
            core[a_idx] <= ADataIn;
        end
    end

    // Read-side next values for both ports and the shared address error.
    always_comb begin
        a_valid_d  = a_acc && !AWe;
        a_data_d   = a_data_q;
        b_valid_d  = b_acc;
        b_data_d   = b_data_q;
        addr_err_d = (a_acc && a_oor) || (b_acc && b_oor);

        if (a_valid_d) begin
            a_data_d = a_oor ? '0 : core[a_idx];
        end

        if (b_acc) begin
            b_data_d = b_oor ? '0 : core[b_idx];
`ifdef DATA_MEM_DP_BYPASS_EN
            if (a_wr_ok && !b_oor && (AAddr == BAddr)) begin
                b_data_d = ADataIn;
            end
`endif
        end
    end

    // Registered read data, valid pulses and address-error pulse.
    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            a_data_q   <= '0;
            b_data_q   <= '0;
            a_valid_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            a_data_q   <= a_data_d;
            b_data_q   <= b_data_d;
            a_valid_q  <= a_valid_d;
            b_valid_q  <= b_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign ARdy     = init_done;
    assign BRdy     = init_done;
    assign InitDone = init_done && (seq_state == RUN);
    assign ADataOut = a_data_q;
    assign BDataOut = b_data_q;
    assign AValid   = a_valid_q;
    assign BValid   = b_valid_q;
    assign AddrErr  = addr_err_q;

endmodule

// File: tb/tb_data_mem_dp.sv
// Bench for data_mem_dp. Two instances share the same stimulus: u_dut with
// DEPTH=256 (full address space) and u_small with DEPTH=200 (out-of-range
// addresses exist). Read results of u_dut go through expected queues.
module tb_data_mem_dp;

    localparam int W = 8;
    localparam int A = 8;

`ifdef DATA_MEM_DP_BYPASS_EN
    localparam logic [W-1:0] COLL_EXP = 8'h33;
`else
    localparam logic [W-1:0] COLL_EXP = 8'h00;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic         a_req, a_we, b_req;
    logic [A-1:0] a_addr, b_addr;
    logic [W-1:0] a_din;

    logic         a_rdy, a_valid, b_rdy, b_valid, init_done, addr_err;
    logic [W-1:0] a_dout, b_dout;
    logic         s_a_rdy, s_a_valid, s_b_rdy, s_b_valid, s_init_done, s_addr_err;
    logic [W-1:0] s_a_dout, s_b_dout;

    data_mem_dp #(.W(W), .A(A), .DEPTH(256)) u_dut (
        .Clk(clk), .ResetN(rst_n),
        .AReq(a_req), .AWe(a_we), .AAddr(a_addr), .ADataIn(a_din),
        .ARdy(a_rdy), .ADataOut(a_dout), .AValid(a_valid),
        .BReq(b_req), .BAddr(b_addr),
        .BRdy(b_rdy), .BDataOut(b_dout), .BValid(b_valid),
        .InitDone(init_done), .AddrErr(addr_err)
    );

    data_mem_dp #(.W(W), .A(A), .DEPTH(200)) u_small (
        .Clk(clk), .ResetN(rst_n),
        .AReq(a_req), .AWe(a_we), .AAddr(a_addr), .ADataIn(a_din),
        .ARdy(s_a_rdy), .ADataOut(s_a_dout), .AValid(s_a_valid),
        .BReq(b_req), .BAddr(b_addr),
        .BRdy(s_b_rdy), .BDataOut(s_b_dout), .BValid(s_b_valid),
        .InitDone(s_init_done), .AddrErr(s_addr_err)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp  = 0;
    int n_fail = 0;
    logic [W-1:0] exp_a_q[$];
    logic [W-1:0] exp_b_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle();
        a_req = 1'b0;
        a_we  = 1'b0;
        b_req = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic a_write(input logic [A-1:0] addr, input logic [W-1:0] data);
        a_req  = 1'b1;
        a_we   = 1'b1;
        a_addr = addr;
        a_din  = data;
    endtask

    task automatic a_read(input logic [A-1:0] addr, input logic [W-1:0] exp);
        a_req  = 1'b1;
        a_we   = 1'b0;
        a_addr = addr;
        exp_a_q.push_back(exp);
    endtask

    task automatic b_read(input logic [A-1:0] addr, input logic [W-1:0] exp);
        b_req  = 1'b1;
        b_addr = addr;
        exp_b_q.push_back(exp);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_big"}, 32'({a_rdy, b_rdy, init_done, a_valid, b_valid, addr_err, a_dout, b_dout}), 32'(0));
        check({tag, "_small"}, 32'({s_a_rdy, s_b_rdy, s_init_done, s_a_valid, s_b_valid, s_addr_err, s_a_dout, s_b_dout}), 32'(0));
    endtask

    // Cycles from reset release until InitDone rises, for both instances.
    task automatic wait_init(output int c_big, output int c_small);
        int c;
        c = 0;
        c_small = -1;
        while (init_done !== 1'b1 && c < 2000) begin
            @(posedge clk);
            #1;
            c++;
            if (s_init_done === 1'b1 && c_small < 0) c_small = c;
        end
        c_big = c;
    endtask

    // ---------------- monitor: pop expected on each valid pulse ----------------
    always @(negedge clk) begin
        if (a_valid === 1'b1) begin
            check("a_queue_nonempty", 32'(exp_a_q.size() > 0), 32'(1));
            if (exp_a_q.size() > 0) check("a_read_data", 32'(a_dout), 32'(exp_a_q.pop_front()));
        end
        if (b_valid === 1'b1) begin
            check("b_queue_nonempty", 32'(exp_b_q.size() > 0), 32'(1));
            if (exp_b_q.size() > 0) check("b_read_data", 32'(b_dout), 32'(exp_b_q.pop_front()));
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed sequence ----------------
    logic [W-1:0] v [10];
    int cb, cs;

    initial begin
        idle();
        a_addr = '0;
        a_din  = '0;
        b_addr = '0;
        rst_n  = 1'b1;
        #3 rst_n = 1'b0;
        #9;
        check_reset_outs("reset_outs");

        // Reset release and init sweep length.
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init(cb, cs);
        check("init_cycles_256", 32'(cb), 32'(256));
        check("init_cycles_200", 32'(cs), 32'(200));

        // Freshly swept memory reads as INIT_VAL (0).
        a_read(8'h00, 8'h00); b_read(8'hFF, 8'h00); tick();
        a_read(8'h7F, 8'h00); b_read(8'h10, 8'h00); tick();

        // Write then read: one-cycle latency, valid is a single pulse.
        @(negedge clk);
        a_write(8'h10, 8'h5A); tick();
        @(negedge clk);
        check("write_no_valid", 32'(a_valid), 32'(0));
        a_read(8'h10, 8'h5A); tick();
        @(negedge clk);
        check("read_valid_pulse", 32'(a_valid), 32'(1));
        check("read_data_latency", 32'(a_dout), 32'(8'h5A));
        @(negedge clk);
        check("valid_one_cycle", 32'(a_valid), 32'(0));
        check("dout_holds", 32'(a_dout), 32'(8'h5A));

        // Same-address A write / B read collision, then both see the new word.
        a_write(8'h20, 8'h33); b_read(8'h20, COLL_EXP); tick();
        a_read(8'h20, 8'h33); b_read(8'h20, 8'h33); tick();

        // Out-of-range on the DEPTH=200 instance.
        a_write(8'd1, 8'h11); tick();
        a_write(8'd201, 8'hFF); tick();
        @(negedge clk);
        check("oor_wr_err", 32'(s_addr_err), 32'(1));
        check("inrange_wr_no_err", 32'(addr_err), 32'(0));
        @(negedge clk);
        check("oor_err_pulse_end", 32'(s_addr_err), 32'(0));
        a_read(8'd201, 8'hFF); tick();
        @(negedge clk);
        check("oor_rd_err", 32'(s_addr_err), 32'(1));
        check("oor_rd_valid", 32'(s_a_valid), 32'(1));
        check("oor_rd_zero", 32'(s_a_dout), 32'(0));
        a_read(8'd1, 8'h11); tick();
        @(negedge clk);
        check("wrap_word_unchanged", 32'(s_a_dout), 32'(8'h11));
        check("inrange_rd_no_err", 32'(s_addr_err), 32'(0));
        b_read(8'd230, 8'h00); tick();
        @(negedge clk);
        check("oor_b_err", 32'(s_addr_err), 32'(1));
        check("oor_b_valid", 32'(s_b_valid), 32'(1));
        check("oor_b_zero", 32'(s_b_dout), 32'(0));

        // Throughput: 10 back-to-back reads on each port.
        for (int i = 0; i < 10; i++) begin
            v[i] = W'($urandom_range(1, 255));
            a_write(8'(64 + i), v[i]); tick();
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            a_read(8'(64 + i), v[i]);
            b_read(8'(73 - i), v[9 - i]);
            @(posedge clk);
            #1;
            idle();
            @(negedge clk);
            check("tput_a_valid", 32'(a_valid), 32'(1));
            check("tput_b_valid", 32'(b_valid), 32'(1));
        end
        @(negedge clk);
        check("tput_valid_drop", 32'({a_valid, b_valid}), 32'(0));

        // Reset in the middle of an accepted read: nothing comes out.
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h40;
        b_req = 1'b1; b_addr = 8'h41;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_reset_outs("reset_mid_read");
        idle();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset in the middle of the sweep: sweep restarts from word 0.
        repeat (100) tick();
        #2 rst_n = 1'b0;
        #1;
        check_reset_outs("reset_mid_sweep");
        @(posedge clk);
        #1 rst_n = 1'b1;
        wait_init(cb, cs);
        check("resweep_cycles_256", 32'(cb), 32'(256));
        check("resweep_cycles_200", 32'(cs), 32'(200));
        a_read(8'h40, 8'h00); b_read(8'h49, 8'h00); tick();
        tick();
        tick();
        check("a_queue_drained", 32'(exp_a_q.size()), 32'(0));
        check("b_queue_drained", 32'(exp_b_q.size()), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_dp.md
DATA_MEM_DP -- requirements
Module: data_mem_dp

Interface
REQ-001 SHALL have parameter W, default 8, data word width in bits.
REQ-002 SHALL have parameter A, default 8, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 2**A, number of words; legal range 1..2**A.
REQ-004 SHALL have parameter INIT_VAL, default 0 (W bits), value written to every word during the init sweep.
REQ-005 Clk  input  1  sole clock; all state changes on the rising edge.
REQ-006 ResetN  input  1  asynchronous, active-low reset.
REQ-007 AReq  input  1  port A request valid.
REQ-008 AWe  input  1  port A request is a write (1) or a read (0).
REQ-009 AAddr  input  A  port A word address.
REQ-010 ADataIn  input  W  port A write data.
REQ-011 ARdy  output  1  port A accepts a request this cycle.
REQ-012 ADataOut  output  W  port A read data.
REQ-013 AValid  output  1  ADataOut is fresh; one-cycle pulse.
REQ-014 BReq  input  1  port B (read-only) request valid.
REQ-015 BAddr  input  A  port B word address.
REQ-016 BRdy  output  1  port B accepts a request this cycle.
REQ-017 BDataOut  output  W  port B read data.
REQ-018 BValid  output  1  BDataOut is fresh; one-cycle pulse.
REQ-019 InitDone  output  1  init sweep complete; memory is usable.
REQ-020 AddrErr  output  1  one-cycle pulse on an accepted request with address >= DEPTH.

Function
REQ-021 SHALL implement a two-state FSM, INIT -> RUN; there is no return to INIT except via reset.
REQ-022 In INIT:
- A sweep counter SHALL write INIT_VAL to word 0, then 1, and so on, one word per cycle.
- The FSM SHALL enter RUN on the cycle after it writes word DEPTH-1, so the sweep takes exactly DEPTH cycles.
REQ-023 ARdy, BRdy and InitDone SHALL be 0 in INIT and 1 in RUN.
- A request (AReq/BReq) presented while its Rdy is 0 SHALL be ignored.
REQ-024 Accepted A write SHALL update Core[AAddr] at that edge; AValid SHALL not pulse for writes.
REQ-025 Read latency SHALL be 1 cycle.
- Accepted read at edge N: DataOut is registered at edge N and Valid=1 for the cycle after edge N.
- DataOut SHALL hold its value until the next accepted read on that port.
REQ-026 Out-of-range address (>= DEPTH) on an accepted request:
- A write SHALL be dropped.
- A read SHALL return 0 with Valid still pulsing.
- AddrErr SHALL pulse (logical OR of both ports) in the cycle after acceptance.
REQ-027 Ports A and B SHALL operate independently in the same cycle, including at the same address.
REQ-028 Same-cycle A write and B read at the same address: the result is governed by the Configuration section.
REQ-029 Back-to-back reads on the same port SHALL sustain 1 per cycle, with Valid staying high.

Reset
REQ-030 On ResetN=0 (asynchronous), the following SHALL apply immediately:
- FSM=INIT, sweep counter=0.
- ARdy=BRdy=InitDone=0, AValid=BValid=0, AddrErr=0, ADataOut=BDataOut=0.
REQ-031 Reset asserted mid-sweep or mid-read SHALL discard the in-flight operation.
- The sweep SHALL restart at word 0 after release.
REQ-032 The memory array itself SHALL not be reset; only the sweep initialises it.

Configuration
REQ-033 Macro DATA_MEM_DP_BYPASS_EN:
- Defined: a same-cycle, same-address A write and B read SHALL return the new ADataIn on BDataOut.
- Undefined: BDataOut SHALL return the old word.

Structure
REQ-034 Package data_mem_dp_pkg SHALL hold:
- The FSM state enum (INIT, RUN).
- Default values for W and A.
REQ-035 The sweep counter and INIT/RUN FSM SHALL be sub-module data_mem_init_seq.
- Outputs: sweep address, sweep write-enable, done.
- The array and both ports SHALL stay in data_mem_dp.

Verification
REQ-036 Reset test. W=8, A=8, DEPTH=256: release reset, then InitDone=0 for 256 cycles and 1 from cycle 257. Then a read of any address returns 0x00.
REQ-037 Read latency test. In RUN, A writes 0x5A to addr 0x10. Next cycle, A reads 0x10. One cycle later, AValid=1 and ADataOut=0x5A.
REQ-038 Same-address collision test. Same cycle: A writes 0x33 to 0x20, B reads 0x20 (old value 0x00). Expected BDataOut: 0x33 with the macro defined, 0x00 without.
REQ-039 Out-of-range test. DEPTH=200: A writes 0xFF to 201, then reads 201. Expected: AddrErr pulses twice, the read returns 0x00, and word 201 mod 200 is unchanged.
REQ-040 Reset mid-sweep test. Pulse ResetN low at sweep cycle 100. Expected: all outputs 0 immediately, and InitDone rises exactly DEPTH cycles after release.
REQ-041 Throughput test. A and B issue 10 consecutive reads each. Expected: AValid and BValid stay high for 10 cycles, with data in request order.
